pcpi_seq_mul_resp: RTL

- PCPI responder (co-processor side) for the PicoRV32 core; the core is the PCPI initiator.
- Decodes RV32M multiply instructions (MUL/MULH/MULHSU/MULHU) presented on PCPI.
- Computes the result with an iterative shift-add multiplier and returns it via the wait/ready/wr handshake.
- Sits beside the core, driven by the same clk; the core's own multiplier is compiled out.

---
 rtl/pcpi_seq_mul_resp.sv | 80 ++++++++
 1 files changed

// File: rtl/pcpi_seq_mul_resp.sv
// pcpi_seq_mul_resp: PCPI RV32M multiply responder (iterative shift-add); define PCPI_SEQ_MUL_EARLY_EN for zero-multiplier early exit
module pcpi_seq_mul_resp #(
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready
);
  localparam int N = 64 / BITS_PER_CYCLE;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t      state, state_n;
  logic        armed, match, accept, last, unused_ok;
  logic [1:0]  op;
  logic [6:0]  cnt;
  logic [63:0] mcand, mplier, acc, acc_nx, mplier_nx, rs1_x, rs2_x;
  assign match = pcpi_insn[6:0] == 7'b0110011 && pcpi_insn[31:25] == 7'b0000001 && !pcpi_insn[14];
  assign accept = state == IDLE && pcpi_valid && match && armed;
  assign rs1_x = {{32{pcpi_rs1[31] & (pcpi_insn[13] ^ pcpi_insn[12])}}, pcpi_rs1};
  assign rs2_x = {{32{pcpi_rs2[31] & (pcpi_insn[13:12] == 2'b01)}}, pcpi_rs2};
  assign acc_nx = acc + mcand * 64'(mplier[BITS_PER_CYCLE-1:0]);
  assign mplier_nx = mplier >> BITS_PER_CYCLE;
`ifdef PCPI_SEQ_MUL_EARLY_EN
  assign last = cnt == 7'(N - 1) || mplier_nx == '0;
`else
  assign last = cnt == 7'(N - 1);
`endif
  assign unused_ok = ^{pcpi_insn[24:15], pcpi_insn[11:7]};
  // next state and handshake outputs decoded from the current state
  always_comb begin
    state_n = state;
    pcpi_wait = 1'b0;
    pcpi_ready = 1'b0;
    pcpi_wr = 1'b0;
    state_n = state == IDLE ? (accept ? BUSY : IDLE) : state == BUSY ? (last ? DONE : BUSY) : IDLE;
    pcpi_wait = state == BUSY;
    pcpi_ready = state == DONE;
    pcpi_wr = state == DONE;
  end
  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  // operand capture, shift-add iteration, result latch and re-arm tracking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed <= 1'b1;
      op <= '0;
      cnt <= '0;
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      pcpi_rd <= '0;
    end else if (state == IDLE) begin
      if (!pcpi_valid) armed <= 1'b1;
      if (accept) begin
        op <= pcpi_insn[13:12];
        mcand <= rs1_x;
        mplier <= rs2_x;
        acc <= '0;
        cnt <= '0;
      end
    end else if (state == BUSY) begin
      acc <= acc_nx;
      mcand <= mcand << BITS_PER_CYCLE;
      mplier <= mplier_nx;
      cnt <= cnt + 7'd1;
      if (last) pcpi_rd <= op == 2'b00 ? acc_nx[31:0] : acc_nx[63:32];
    end else begin
      armed <= 1'b0;
    end
  end
endmodule
